// File: rtl/nd_2to1_pkg.sv
`default_nettype none
// ============================================================================
// nd_2to1_pkg -- constants and arbitration helpers shared by the merge/split nodes
// Rev 1.0
// ============================================================================
package nd_2to1_pkg;

  localparam logic ON  = 1'b1;
  localparam logic OFF = 1'b0;

  localparam int ADDRESS_SIZE   = 8;
  localparam int DATA_SIZE      = 8;
  localparam int FIFO_ADDR_BITS = 2;

  typedef enum logic {
    SEL_IN0 = 1'b0,
    SEL_IN1 = 1'b1
  } sel_e;

  // Both pending: honour the priority pointer; otherwise take whichever has data.
  function automatic sel_e rr_pick(input logic ne0, input logic ne1, input sel_e prio);
    if (ne0 && ne1) begin
      return prio;
    end
    return ne0 ? SEL_IN0 : SEL_IN1;
  endfunction

  function automatic sel_e rr_other(input sel_e s);
    return (s == SEL_IN0) ? SEL_IN1 : SEL_IN0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/nd_2to1_if.sv
`default_nettype none
// ============================================================================
// nd_2to1_if -- 4-phase req/ack message channel ({dst, dat}) with master/slave views
// Rev 1.0
// ============================================================================
interface nd_2to1_if #(
  parameter int ASZ = nd_2to1_pkg::ADDRESS_SIZE,
  parameter int DSZ = nd_2to1_pkg::DATA_SIZE
);

  logic [ASZ-1:0] dst;
  logic [DSZ-1:0] dat;
  logic           req;
  logic           ack;

  modport master (
    output dst,
    output dat,
    output req,
    input  ack
  );

  modport slave (
    input  dst,
    input  dat,
    input  req,
    output ack
  );

endinterface
`default_nettype wire

// File: rtl/nd_2to1_msg_fifo.sv
`default_nettype none
// ============================================================================
// nd_msg_fifo -- show-ahead message FIFO, 2**FSZ entries, wrap-bit full/empty
// Rev 1.0
// ============================================================================
module nd_msg_fifo
  import nd_2to1_pkg::*;
#(
  parameter int ASZ = ADDRESS_SIZE,
  parameter int DSZ = DATA_SIZE,
  parameter int FSZ = FIFO_ADDR_BITS
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           wr_en_i,
  input  logic [ASZ-1:0] wr_dst_i,
  input  logic [DSZ-1:0] wr_dat_i,
  input  logic           rd_en_i,
  output logic [ASZ-1:0] rd_dst_o,
  output logic [DSZ-1:0] rd_dat_o,
  output logic           full_o,
  output logic           empty_o
);

  localparam int             DEPTH   = 2 ** FSZ;
  localparam int             MSZ     = ASZ + DSZ;
  localparam logic [FSZ:0]   PTR_ONE = {{FSZ{1'b0}}, 1'b1};

  logic [MSZ-1:0] mem_q [DEPTH];
  logic [FSZ:0]   head_q, head_d;
  logic [FSZ:0]   tail_q, tail_d;
  logic           w_wr;
  logic           w_rd;

  // Extra MSB on each pointer separates "full" from "empty" when the indices match.
  always_comb begin
    full_o  = (head_q[FSZ] != tail_q[FSZ]) && (head_q[FSZ-1:0] == tail_q[FSZ-1:0]);
    empty_o = (head_q == tail_q);
    w_wr    = wr_en_i && !full_o;
    w_rd    = rd_en_i && !empty_o;
    head_d  = w_wr ? (head_q + PTR_ONE) : head_q;
    tail_d  = w_rd ? (tail_q + PTR_ONE) : tail_q;
  end

  assign {rd_dst_o, rd_dat_o} = mem_q[tail_q[FSZ-1:0]];

  always_ff @(posedge i_clk) begin
    if (w_wr) begin
      mem_q[head_q[FSZ-1:0]] <= {wr_dst_i, wr_dat_i};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/nd_2to1.sv
`default_nettype none
// ============================================================================
// nd_2to1 -- two-input merge node: per-input FIFOs, round-robin onto one channel
// Rev 1.0
// ============================================================================
module nd_2to1
  import nd_2to1_pkg::*;
#(
  parameter int ASZ = ADDRESS_SIZE,
  parameter int DSZ = DATA_SIZE,
  parameter int FSZ = FIFO_ADDR_BITS
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  nd_2to1_if.master  snd0,
  nd_2to1_if.slave   rcv0,
  nd_2to1_if.slave   rcv1
);

  logic           ack0_q, ack0_d;
  logic           ack1_q, ack1_d;
  logic           req_q,  req_d;
  logic [ASZ-1:0] dst_q,  dst_d;
  logic [DSZ-1:0] dat_q,  dat_d;
  sel_e           prio_q, prio_d;

  logic           w_wr0, w_wr1;
  logic           w_rd0, w_rd1;
  logic           w_full0, w_full1;
  logic           w_empty0, w_empty1;
  logic [ASZ-1:0] w_dst0, w_dst1;
  logic [DSZ-1:0] w_dat0, w_dat1;
  logic           w_load;
  sel_e           w_sel;

  nd_msg_fifo #(.ASZ(ASZ), .DSZ(DSZ), .FSZ(FSZ)) u_fifo0 (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .wr_en_i  (w_wr0),
    .wr_dst_i (rcv0.dst),
    .wr_dat_i (rcv0.dat),
    .rd_en_i  (w_rd0),
    .rd_dst_o (w_dst0),
    .rd_dat_o (w_dat0),
    .full_o   (w_full0),
    .empty_o  (w_empty0)
  );

  nd_msg_fifo #(.ASZ(ASZ), .DSZ(DSZ), .FSZ(FSZ)) u_fifo1 (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .wr_en_i  (w_wr1),
    .wr_dst_i (rcv1.dst),
    .wr_dat_i (rcv1.dat),
    .rd_en_i  (w_rd1),
    .rd_dst_o (w_dst1),
    .rd_dat_o (w_dat1),
    .full_o   (w_full1),
    .empty_o  (w_empty1)
  );

  always_comb begin
    ack0_d = ack0_q;
    ack1_d = ack1_q;
    req_d  = req_q;
    dst_d  = dst_q;
    dat_d  = dat_q;
    prio_d = prio_q;

    // A full FIFO simply withholds ack; the sender keeps req up until space frees.
    w_wr0 = rcv0.req && !ack0_q && !w_full0;
    w_wr1 = rcv1.req && !ack1_q && !w_full1;

    if (w_wr0) begin
      ack0_d = ON;
    end else if (!rcv0.req && ack0_q) begin
      ack0_d = OFF;
    end

    if (w_wr1) begin
      ack1_d = ON;
    end else if (!rcv1.req && ack1_q) begin
      ack1_d = OFF;
    end

    w_sel  = rr_pick(!w_empty0, !w_empty1, prio_q);
    w_load = !req_q && !snd0.ack && (!w_empty0 || !w_empty1);
    w_rd0  = w_load && (w_sel == SEL_IN0);
    w_rd1  = w_load && (w_sel == SEL_IN1);

    if (w_load) begin
      req_d  = ON;
      prio_d = rr_other(w_sel);
      if (w_sel == SEL_IN0) begin
        dst_d = w_dst0;
        dat_d = w_dat0;
      end else begin
        dst_d = w_dst1;
        dat_d = w_dat1;
      end
    end else if (req_q && snd0.ack) begin
      req_d = OFF;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ack0_q <= OFF;
      ack1_q <= OFF;
      req_q  <= OFF;
      dst_q  <= '0;
      dat_q  <= '0;
      prio_q <= SEL_IN0;
    end else begin
      ack0_q <= ack0_d;
      ack1_q <= ack1_d;
      req_q  <= req_d;
      dst_q  <= dst_d;
      dat_q  <= dat_d;
      prio_q <= prio_d;
    end
  end

  assign snd0.req = req_q;
  assign snd0.dst = dst_q;
  assign snd0.dat = dat_q;
  assign rcv0.ack = ack0_q;
  assign rcv1.ack = ack1_q;

endmodule
`default_nettype wire

// File: tb/tb_nd_2to1.sv
`default_nettype none
// ============================================================================
// tb_nd_2to1 -- directed self-checking bench for the two-input merge node
// Rev 1.0
// ============================================================================
module tb_nd_2to1;

  logic clk;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  nd_2to1_if #(.ASZ(8), .DSZ(8)) snd0 ();
  nd_2to1_if #(.ASZ(8), .DSZ(8)) rcv0 ();
  nd_2to1_if #(.ASZ(8), .DSZ(8)) rcv1 ();

  nd_2to1 #(.ASZ(8), .DSZ(8), .FSZ(2)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .snd0    (snd0),
    .rcv0    (rcv0),
    .rcv1    (rcv1)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not complete, observed timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic ack_of(input int k);
    return (k == 0) ? rcv0.ack : rcv1.ack;
  endfunction

  task automatic wait_ack(input int k, input logic v, input string tag);
    int n = 0;
    while (ack_of(k) !== v && n < 50) begin
      tick();
      n++;
    end
    chk(tag, 32'(ack_of(k)), 32'(v));
  endtask

  task automatic send(input int k, input logic [7:0] d, input logic [7:0] t);
    if (k == 0) begin
      rcv0.dst = d; rcv0.dat = t; rcv0.req = 1'b1;
    end else begin
      rcv1.dst = d; rcv1.dat = t; rcv1.req = 1'b1;
    end
    wait_ack(k, 1'b1, "send_ack");
    if (k == 0) rcv0.req = 1'b0;
    else        rcv1.req = 1'b0;
    wait_ack(k, 1'b0, "send_release");
  endtask

  task automatic send_both(input logic [7:0] d0, input logic [7:0] t0,
                           input logic [7:0] d1, input logic [7:0] t1);
    int n = 0;
    rcv0.dst = d0; rcv0.dat = t0;
    rcv1.dst = d1; rcv1.dat = t1;
    rcv0.req = 1'b1;
    rcv1.req = 1'b1;
    while (!(rcv0.ack === 1'b1 && rcv1.ack === 1'b1) && n < 50) begin
      tick();
      n++;
    end
    chk("both_ack0", 32'(rcv0.ack), 1);
    chk("both_ack1", 32'(rcv1.ack), 1);
    rcv0.req = 1'b0;
    rcv1.req = 1'b0;
    n = 0;
    while (!(rcv0.ack === 1'b0 && rcv1.ack === 1'b0) && n < 50) begin
      tick();
      n++;
    end
    chk("both_release", 32'({rcv1.ack, rcv0.ack}), 0);
  endtask

  task automatic recv(input logic [7:0] d, input logic [7:0] t, input int dly, input string tag);
    int n = 0;
    while (snd0.req !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk({tag, "_req"}, 32'(snd0.req), 1);
    chk({tag, "_dst"}, 32'(snd0.dst), 32'(d));
    chk({tag, "_dat"}, 32'(snd0.dat), 32'(t));
    repeat (dly) tick();
    snd0.ack = 1'b1;
    n = 0;
    while (snd0.req !== 1'b0 && n < 50) begin
      tick();
      n++;
    end
    chk({tag, "_rel"}, 32'(snd0.req), 0);
    snd0.ack = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    rcv0.req = 1'b0; rcv0.dst = '0; rcv0.dat = '0;
    rcv1.req = 1'b0; rcv1.dst = '0; rcv1.dat = '0;
    snd0.ack = 1'b0;
    tick();
    tick();
    chk("rst_snd_req",  32'(snd0.req), 0);
    chk("rst_rcv0_ack", 32'(rcv0.ack), 0);
    chk("rst_rcv1_ack", 32'(rcv1.ack), 0);
    chk("rst_snd_dst",  32'(snd0.dst), 0);
    chk("rst_snd_dat",  32'(snd0.dat), 0);
    rst_n = 1'b1;
    tick();

    // Single message with cycle-exact handshake timing.
    rcv0.dst = 8'h05; rcv0.dat = 8'h11; rcv0.req = 1'b1;
    tick();
    chk("single_ack",       32'(rcv0.ack), 1);
    chk("single_req_early", 32'(snd0.req), 0);
    tick();
    chk("single_req", 32'(snd0.req), 1);
    chk("single_dst", 32'(snd0.dst), 32'h05);
    chk("single_dat", 32'(snd0.dat), 32'h11);
    rcv0.req = 1'b0;
    tick();
    chk("single_ack_low", 32'(rcv0.ack), 0);
    chk("single_req_hold", 32'(snd0.req), 1);
    tick();
    snd0.ack = 1'b1;
    tick();
    chk("single_release",    32'(snd0.req), 0);
    chk("single_dst_stable", 32'(snd0.dst), 32'h05);
    snd0.ack = 1'b0;
    tick();

    // Contention: A0 leaves alone, the rest alternate.
    for (int i = 0; i < 3; i++) send(0, 8'(8'hA0 + i), 8'(8'h10 + i));
    for (int i = 0; i < 3; i++) send(1, 8'(8'hB0 + i), 8'(8'h20 + i));
    for (int i = 0; i < 3; i++) begin
      recv(8'(8'hA0 + i), 8'(8'h10 + i), 1, "cont_a");
      recv(8'(8'hB0 + i), 8'(8'h20 + i), 1, "cont_b");
    end

    // Backpressure: output register plus four FIFO slots, sixth request stalls.
    for (int i = 0; i < 5; i++) send(1, 8'(8'h60 + i), 8'(8'h70 + i));
    rcv1.dst = 8'h65; rcv1.dat = 8'h75; rcv1.req = 1'b1;
    repeat (4) tick();
    chk("bp_withheld", 32'(rcv1.ack), 0);
    chk("bp_out_held", 32'(snd0.req), 1);
    recv(8'h60, 8'h70, 0, "bp0");
    wait_ack(1, 1'b1, "bp_late_ack");
    rcv1.req = 1'b0;
    wait_ack(1, 1'b0, "bp_late_rel");
    for (int i = 1; i < 6; i++) recv(8'(8'h60 + i), 8'(8'h70 + i), 0, "bp");

    // Single-source grants leave priority pointing at input 0.
    for (int i = 0; i < 3; i++) begin
      send(1, 8'(8'h80 + i), 8'(8'h90 + i));
      recv(8'(8'h80 + i), 8'(8'h90 + i), 0, "ss_solo");
    end
    send_both(8'h0A, 8'h1A, 8'h0B, 8'h1B);
    recv(8'h0A, 8'h1A, 0, "ss_first");
    recv(8'h0B, 8'h1B, 0, "ss_second");

    // Reset mid-operation: C0 in output register, C1/C2 in FIFO0, rcv1 mid-handshake.
    for (int i = 0; i < 3; i++) send(0, 8'(8'hC0 + i), 8'(8'hD0 + i));
    chk("mid_out_busy", 32'(snd0.req), 1);
    chk("mid_out_dst",  32'(snd0.dst), 32'hC0);
    rcv1.dst = 8'hEE; rcv1.dat = 8'hEF; rcv1.req = 1'b1;
    tick();
    chk("mid_rcv1_ack", 32'(rcv1.ack), 1);
    #5;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req",  32'(snd0.req), 0);
    chk("mid_rst_ack0", 32'(rcv0.ack), 0);
    chk("mid_rst_ack1", 32'(rcv1.ack), 0);
    chk("mid_rst_dst",  32'(snd0.dst), 0);
    rcv1.req = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    chk("mid_no_stale", 32'(snd0.req), 0);
    send_both(8'h31, 8'h41, 8'h32, 8'h42);
    recv(8'h31, 8'h41, 0, "post_rst_first");
    recv(8'h32, 8'h42, 0, "post_rst_second");

    // Wrap-around: twenty messages through input 0 with random downstream delay.
    for (int b = 0; b < 5; b++) begin
      for (int j = 0; j < 4; j++) send(0, 8'(b * 4 + j), 8'(8'hC0 + b * 4 + j));
      for (int j = 0; j < 4; j++)
        recv(8'(b * 4 + j), 8'(8'hC0 + b * 4 + j), int'($urandom_range(0, 3)), "wrap");
    end
    repeat (3) tick();
    chk("wrap_idle", 32'(snd0.req), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/nd_2to1.md
Name: nd_2to1

Overview:
- Two-input, one-output merge node; the inverse of the 1-to-2 split node.
- Accepts messages ({dst, dat}) on two independent 4-phase req/ack input channels and buffers each in its own FIFO.
- Forwards messages on a single output channel under round-robin arbitration, unmodified.
- Sits at fan-in points of the cell message network, where two routes re-converge before a downstream node.

Parameters:
- ASZ, `ADDRESS_SIZE: width of the dst field.
- DSZ, `DATA_SIZE: width of the dat field.
- FSZ, 2: FIFO address bits; each input FIFO holds 2**FSZ messages (default 4).

Ports:
- i_clk  in  1  main clock (25 MHz).
- i_rst_n  in  1  asynchronous active-low reset.
- snd0_dst  out  ASZ  output message destination.
- snd0_dat  out  DSZ  output message data.
- snd0_req  out  1  output request.
- snd0_ack  in  1  output acknowledge from downstream.
- rcv0_dst  in  ASZ  input 0 message destination.
- rcv0_dat  in  DSZ  input 0 message data.
- rcv0_req  in  1  input 0 request.
- rcv0_ack  out  1  input 0 acknowledge.
- rcv1_dst, rcv1_dat, rcv1_req, rcv1_ack: same as rcv0, for input 1.

Behaviour:
- Protocol: 4-phase. The sender holds dst/dat stable from raising req until it sees ack. req low, then ack low, returns to idle.
- Reset: asynchronous on i_rst_n low; all state changes on posedge i_clk.
  - snd0_req, rcv0_ack, rcv1_ack = OFF; snd0_dst/dat = 0.
  - Both FIFOs empty; priority pointer prio = 0.
  - Reset mid-handshake drops all req/ack immediately. A message held in the output register is discarded. A message acked but not yet forwarded is discarded.
- Input k (k = 0, 1), evaluated independently each cycle:
  - If rcvk_req && !rcvk_ack && FIFO k not full: write {rcvk_dst, rcvk_dat} at the head and set rcvk_ack <= ON.
  - If FIFO k is full: ack is withheld and req stays pending; no loss, no overwrite.
  - If !rcvk_req && rcvk_ack: rcvk_ack <= OFF.
- Output load:
  - Condition: !snd0_req && !snd0_ack && (FIFO0 or FIFO1 non-empty, by pre-edge state).
  - Pop the selected FIFO tail into the output register and set snd0_req <= ON.
  - Release: if snd0_req && snd0_ack, snd0_req <= OFF. The next load waits until snd0_ack is low.
- Arbitration:
  - Both non-empty: grant input prio, then prio <= other input.
  - One non-empty: grant it, then prio <= the other input.
  - prio changes only on a load.
- FIFO behaviour:
  - Full and empty use pre-edge occupancy. Write and read in the same cycle on the same FIFO are allowed when not empty/full.
  - A write into an empty FIFO becomes poppable the next cycle.
  - Pointers are FSZ+1 bits and wrap modulo 2**(FSZ+1). Full when the low bits are equal and the MSBs differ; empty when the pointers are equal.
- Latency: input accepted at edge N (ack high after N); earliest snd0_req high after edge N+1.
- Ordering: per-input order preserved; no ordering guarantee between inputs.
- Output data changes only on a load; it is stable while snd0_req is high.

Decomposition:
- Shared global header: ON/OFF, TRUE/FALSE, ADDRESS_SIZE, DATA_SIZE, and the channel, message-register, and FIFO declaration macros. These macros are shared with the 1-to-2 split node.
- One natural sub-module: nd_msg_fifo (params ASZ, DSZ, FSZ).
  - Ports: write enable + message in, read enable + message out, full, empty.
  - Instantiated twice.
- The arbiter and handshake logic stay in nd_2to1.

Test Plan:
- Single message: rcv0 sends dst=5, dat=0x11; downstream acks after 2 cycles -> rcv0_ack high 1 cycle after req; snd0_req high 1 cycle later with dst=5, dat=0x11; snd0_req drops after ack.
- Contention: both FIFOs preloaded with 3 messages each (rcv0: A0..A2, rcv1: B0..B2), prio=0 -> output order A0, B0, A1, B1, A2, B2.
- Backpressure: snd0_ack never asserted, rcv1 sends 6 messages -> 5 accepted (4 in FIFO + 1 in output register); the 6th req stays pending with ack low. After downstream acks resume, all 6 emerge in order.
- Single-source prio update: only rcv1 active, 3 messages; then rcv0 and rcv1 each send one message simultaneously -> rcv0's message is granted first (prio=0 after last rcv1 grant).
- Wrap-around: FSZ=2, stream 20 messages through rcv0 with random downstream ack delay 0–3 cycles -> all 20 out, in order, no drops or duplicates.
- Reset mid-op: assert i_rst_n=0 while snd0_req=1 and FIFO0 holds 2 messages -> snd0_req, rcv*_ack low immediately; after release the FIFOs are empty and no stale message is emitted.
